// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter sharing a single-port on-chip RAM whose read
// data arrives one cycle after the address; read data is steered back by owner.
module onchip_mem_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int BE_W           = 4,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic req0_s;
   logic req1_s;
   logic grant_valid_s;
   logic grant_sel_s;
   logic win_write_s;
   logic win_read_s;
   logic last_grant_r;
   logic rd_pending_r;
   logic rd_owner_r;

   // Request decode and arbitration; no grant is ever issued while in reset
   always_comb begin
      req0_s        = m0_read | m0_write;
      req1_s        = m1_read | m1_write;
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
      if (reset) begin
         grant_valid_s = 1'b0;
         grant_sel_s   = 1'b0;
      end else begin
         case ({req1_s, req0_s})
            2'b01: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = 1'b0;
            end
            2'b10: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = 1'b1;
            end
            2'b11: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_r;
            end
            default: begin
               grant_valid_s = 1'b0;
               grant_sel_s   = 1'b0;
            end
         endcase
      end
   end

   // Winner command decode: write takes precedence over a simultaneous read
   always_comb begin
      win_write_s = 1'b0;
      win_read_s  = 1'b0;
      if (grant_sel_s) begin
         win_write_s = m1_write;
         win_read_s  = m1_read & ~m1_write;
      end else begin
         win_write_s = m0_write;
         win_read_s  = m0_read & ~m0_write;
      end
   end

   // RAM port mux; master 0 fields pass through when idle
   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      if (grant_sel_s) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end else begin
         mem_address    = m0_address;
         mem_byteenable = m0_byteenable;
         mem_writedata  = m0_writedata;
      end
      mem_chipselect = grant_valid_s;
      mem_write      = grant_valid_s & win_write_s;
      mem_clken      = ~reset;
      m0_waitrequest = ~(grant_valid_s & ~grant_sel_s);
      m1_waitrequest = ~(grant_valid_s & grant_sel_s);
   end

   // Arbitration history and outstanding-read tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= 1'b1;
         rd_pending_r <= 1'b0;
         rd_owner_r   <= 1'b0;
      end else begin
         if (grant_valid_s) begin
            last_grant_r <= grant_sel_s;
         end else begin
            last_grant_r <= last_grant_r;
         end
         rd_pending_r <= grant_valid_s & win_read_s;
         if (grant_valid_s & win_read_s) begin
            rd_owner_r <= grant_sel_s;
         end else begin
            rd_owner_r <= rd_owner_r;
         end
      end
   end

   // Both masters see the RAM data; only the owner's valid strobe qualifies it
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pending_r & ~rd_owner_r;
   assign m1_readdatavalid = rd_pending_r & rd_owner_r;

endmodule
